// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART FIFO pointer/flag controller.
package uart_fifo_pkg;

   // Default number of FIFO entries (power of two, >= 4).
   localparam int DEFAULT_DEPTH    = 16;

   // Default almost_empty threshold: asserted while count <= this level.
   localparam int DEFAULT_AE_LEVEL = 2;

   // Headroom below depth at which almost_full asserts by default.
   localparam int DEFAULT_AF_SLACK = 2;

   // Occupancy needs one extra bit over the address so it can hold 0..depth.
   function automatic int count_width(input int pointer_width);
      return pointer_width + 1;
   endfunction

endpackage : uart_fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrap counter for one FIFO pointer. The counter is one bit wider than the
// array address; the extra MSB toggles on every lap so full and empty can be
// told apart when the address bits match.
module fifo_ptr #(
   parameter int width = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   output logic [width-1:0] ptr,
   output logic [width-1:0] ptr_next
);

   localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

   // Next pointer value; flush wins over advance. Natural binary wrap works
   // because the depth is a power of two.
   always_comb begin
      ptr_next = ptr;
      if (rst || clear) begin
         ptr_next = '0;
      end else if (en) begin
         ptr_next = ptr + one;
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      ptr <= ptr_next;
   end

endmodule : fifo_ptr

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for the UART FIFO storage array.
//
// Request semantics: push and pop are single-cycle requests, not a
// valid/ready pair. A push is accepted when full=0 in that same cycle
// (the array uses the identical gate), a pop when empty=0. Rejected
// requests are dropped, never stalled, and latch the sticky overflow /
// underflow flags. All flags are registered from next-state values so they
// reflect an accepted request one cycle later.
module fifo_ctrl
   import uart_fifo_pkg::*;
#(
   parameter int depth         = DEFAULT_DEPTH,
   parameter int pointer_width = $clog2(depth),
   parameter int af_level      = depth - DEFAULT_AF_SLACK,
   parameter int ae_level      = DEFAULT_AE_LEVEL
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   output logic [pointer_width-1:0] wr_ptr,
   output logic [pointer_width-1:0] rd_ptr,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [pointer_width:0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int cw = count_width(pointer_width);

   localparam logic [cw-1:0] af_thr = cw'(af_level);
   localparam logic [cw-1:0] ae_thr = cw'(ae_level);

   logic          wr_en;
   logic          rd_en;
   logic [cw-1:0] wr_ext;
   logic [cw-1:0] rd_ext;
   logic [cw-1:0] wr_ext_next;
   logic [cw-1:0] rd_ext_next;
   logic [cw-1:0] count_next;
   logic          full_next;
   logic          empty_next;

   // Accepted transfers use the current registered flags, matching the array.
   always_comb begin
      wr_en = push && !full;
      rd_en = pop && !empty;
   end

   fifo_ptr #(.width(cw)) u_wr_ptr (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .en       (wr_en),
      .ptr      (wr_ext),
      .ptr_next (wr_ext_next)
   );

   fifo_ptr #(.width(cw)) u_rd_ptr (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .en       (rd_en),
      .ptr      (rd_ext),
      .ptr_next (rd_ext_next)
   );

   // Array addresses are the low bits of the extended pointers.
   always_comb begin
      wr_ptr = wr_ext[pointer_width-1:0];
      rd_ptr = rd_ext[pointer_width-1:0];
   end

   // Next-state occupancy and pointer-derived flags.
   always_comb begin
      count_next = count + cw'(wr_en) - cw'(rd_en);
      full_next  = (wr_ext_next[cw-1] != rd_ext_next[cw-1]) &&
                   (wr_ext_next[cw-2:0] == rd_ext_next[cw-2:0]);
      empty_next = (wr_ext_next == rd_ext_next);
   end

   // Registered count and flags; clear behaves exactly like rst.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         count        <= count_next;
         full         <= full_next;
         empty        <= empty_next;
         almost_full  <= (count_next >= af_thr);
         almost_empty <= (count_next <= ae_thr);
         overflow     <= overflow  | (push && full);
         underflow    <= underflow | (pop && empty);
      end
   end

endmodule : fifo_ctrl
